// File: rtl/echo_window_acc.sv
// Per-echo integrator: sums ADC samples over eight windows separated by gaps and publishes all
// eight sums together once per frame. Optional frame counter output when ECHO_FRAME_CNT_EN is defined.
module echo_window_acc #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  win_len,
  input  logic [LEN_W-1:0]  gap_len,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  dataone,
  output logic [ACC_W-1:0]  datatwo,
  output logic [ACC_W-1:0]  datathree,
  output logic [ACC_W-1:0]  datafour,
  output logic [ACC_W-1:0]  datafive,
  output logic [ACC_W-1:0]  datasix,
  output logic [ACC_W-1:0]  dataseven,
  output logic [ACC_W-1:0]  dataeight
`ifdef ECHO_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_winLen;
  logic [LEN_W-1:0]  r_gapLen;
  logic [LEN_W-1:0]  r_cnt;
  logic [2:0]        r_idx;
  logic [ACC_W-1:0]  r_work [8];
  logic [ACC_W-1:0]  r_out  [8];
  logic              r_done;
  logic              w_accept;
  logic              w_abort;
  logic              w_winEnd;
  logic              w_gapEnd;
  logic [ACC_W-1:0]  w_sample;
`ifdef ECHO_FRAME_CNT_EN
  logic [15:0]       r_frameCnt;
`endif

  assign w_accept = (r_state == S_IDLE) && start && (win_len != '0) && !abort;
  assign w_abort  = abort && (r_state != S_IDLE);
  assign w_winEnd = (r_state == S_ACC) && adc_valid && (r_cnt == r_winLen - LEN_ONE);
  assign w_gapEnd = (r_state == S_GAP) && adc_valid && (r_cnt == r_gapLen - LEN_ONE);
  assign w_sample = {{(ACC_W-DATA_W){1'b0}}, adc_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort wins over every transition, including the FIN publish.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_ACC;
      S_ACC: begin
        if (w_winEnd) begin
          if (r_idx == 3'd7)          w_next = S_FIN;
          else if (r_gapLen == '0)    w_next = S_ACC;
          else                        w_next = S_GAP;
        end
      end
      S_GAP:   if (w_gapEnd) w_next = S_ACC;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winLen <= '0;
      r_gapLen <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_work[i] <= '0;
        r_out[i]  <= '0;
      end
`ifdef ECHO_FRAME_CNT_EN
      r_frameCnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_winLen <= win_len;
              r_gapLen <= gap_len;
              r_cnt    <= '0;
              r_idx    <= '0;
              for (int i = 0; i < 8; i++) r_work[i] <= '0;
            end
          end
          S_ACC: begin
            if (adc_valid) begin
              r_work[r_idx] <= r_work[r_idx] + w_sample;
              if (w_winEnd) begin
                r_cnt <= '0;
                if (r_idx != 3'd7) r_idx <= r_idx + 3'd1;
              end else begin
                r_cnt <= r_cnt + LEN_ONE;
              end
            end
          end
          S_GAP: begin
            if (adc_valid) r_cnt <= w_gapEnd ? '0 : r_cnt + LEN_ONE;
          end
          S_FIN: begin
            for (int i = 0; i < 8; i++) r_out[i] <= r_work[i];
            r_done <= 1'b1;
`ifdef ECHO_FRAME_CNT_EN
            r_frameCnt <= r_frameCnt + 16'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dataone   = r_out[0];
  assign datatwo   = r_out[1];
  assign datathree = r_out[2];
  assign datafour  = r_out[3];
  assign datafive  = r_out[4];
  assign datasix   = r_out[5];
  assign dataseven = r_out[6];
  assign dataeight = r_out[7];
`ifdef ECHO_FRAME_CNT_EN
  assign frame_cnt = r_frameCnt;
`endif

endmodule

// File: tb/tb_echo_window_acc.sv
// Bench for echo_window_acc: directed and random frames checked against a window-sum model
// built from the list of valid samples.
module tb_echo_window_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  win_len;
  logic [7:0]  gap_len;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic        done;
  logic [19:0] dOut [8];
`ifdef ECHO_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int          nAssert = 0;
  int          nFail   = 0;
  logic [19:0] expOut [8];
  int          expFrames = 0;

  echo_window_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .win_len   (win_len),
    .gap_len   (gap_len),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .busy      (busy),
    .done      (done),
    .dataone   (dOut[0]),
    .datatwo   (dOut[1]),
    .datathree (dOut[2]),
    .datafour  (dOut[3]),
    .datafive  (dOut[4]),
    .datasix   (dOut[5]),
    .dataseven (dOut[6]),
    .dataeight (dOut[7])
`ifdef ECHO_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllOutputs(input string tag);
    for (int w = 0; w < 8; w++) checkOutput($sformatf("%s_data%0d", tag, w + 1), 32'(dOut[w]), 32'(expOut[w]));
`ifdef ECHO_FRAME_CNT_EN
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(expFrames % 65536));
`endif
  endtask

  // Issues a start at the current time; the following edge accepts it.
  task automatic startFrame(input int win, input int gap);
    win_len = 8'(win);
    gap_len = 8'(gap);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Feeds one full frame. vMode: 0 always valid, 1 toggle, 2 random. dMode: 0 const, 1 ramp, 2 random.
  task automatic applyStimulus(input int win, input int gap, input int vMode, input int dMode,
                               input int cval, input int reStartAt, input string tag);
    int q[$];
    int fed = 0;
    int n   = 8 * win + 7 * gap;
    bit tog = 1'b1;
    bit v;
    int d;
    while (fed < n) begin
      case (vMode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      case (dMode)
        0:       d = cval;
        1:       d = fed + 1;
        default: d = int'($urandom_range(0, 4095));
      endcase
      adc_valid = v;
      adc_data  = d[11:0];
      start     = 1'b0;
      if (fed == reStartAt && v) begin
        start   = 1'b1;
        win_len = 8'd1;
        gap_len = 8'd0;
      end
      if (v) begin
        q.push_back(d);
        fed++;
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    adc_valid = 1'b0;
    checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_fin"}, 32'(busy), 32'd1);
    for (int w = 0; w < 8; w++) begin
      int s = 0;
      for (int k = 0; k < win; k++) s += q[w * (win + gap) + k];
      expOut[w] = s[19:0];
    end
    expFrames++;
    @(posedge clk); #1;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
    checkAllOutputs(tag);
  endtask

  // Starts a frame, feeds it partially, then aborts it.
  task automatic abortFrame(input int win, input int gap, input int abortAt, input int reStartAt);
    int fed = 0;
    startFrame(win, gap);
    while (fed <= abortAt) begin
      adc_valid = 1'b1;
      adc_data  = 12'($urandom_range(0, 4095));
      start     = (fed == reStartAt);
      abort     = (fed == abortAt);
      fed++;
      @(posedge clk); #1;
      checkOutput("abort_busy", 32'(busy), 32'(fed <= abortAt));
    end
    abort     = 1'b0;
    start     = 1'b0;
    checkOutput("abort_no_done", 32'(done), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
    checkOutput("abort_still_idle", 32'(busy), 32'd0);
    checkOutput("abort_no_late_done", 32'(done), 32'd0);
    checkAllOutputs("abort_hold");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; win_len = '0; gap_len = '0;
    adc_data = '0; adc_valid = 1'b0;
    for (int w = 0; w < 8; w++) expOut[w] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkAllOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] win=4 gap=2 const 100");
    startFrame(4, 2);
    applyStimulus(4, 2, 0, 0, 100, -1, "t2");
    checkOutput("t2_dataeight_400", 32'(dOut[7]), 32'd400);

    $display("[TB] back-to-back: win=3 gap=1 toggled valid, ramp");
    startFrame(3, 1);
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    applyStimulus(3, 1, 1, 1, 0, -1, "t4");
    checkOutput("t4_dataone", 32'(dOut[0]), 32'd6);
    checkOutput("t4_datatwo", 32'(dOut[1]), 32'd18);
    checkOutput("t4_dataeight", 32'(dOut[7]), 32'd90);

    @(posedge clk); #1;
    $display("[TB] win=255 gap=0 full scale");
    startFrame(255, 0);
    applyStimulus(255, 0, 0, 0, 4095, -1, "t3");
    checkOutput("t3_dataone_max", 32'(dOut[0]), 32'hFEF01);

    @(posedge clk); #1;
    $display("[TB] frame A, then start-while-busy ignored");
    startFrame(4, 2);
    applyStimulus(4, 2, 0, 0, 100, -1, "t5a");
    startFrame(4, 2);
    applyStimulus(4, 2, 2, 2, 0, 7, "t5re");
    @(posedge clk); #1;
    startFrame(4, 2);
    applyStimulus(4, 2, 0, 0, 100, -1, "t5b");
    @(posedge clk); #1;
    abortFrame(4, 2, 13, 7);

    $display("[TB] ignored starts");
    win_len = 8'd0; gap_len = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("start_winlen0_ignored", 32'(busy), 32'd0);
    win_len = 8'd2; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("start_with_abort_ignored", 32'(busy), 32'd0);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      int w = int'($urandom_range(1, 6));
      int g = int'($urandom_range(0, 3));
      startFrame(w, g);
      applyStimulus(w, g, 2, 2, 0, -1, $sformatf("rnd%0d", f));
      if (f[0]) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] reset mid-frame");
    startFrame(5, 1);
    repeat (7) begin
      adc_valid = 1'b1;
      adc_data  = 12'($urandom_range(1, 4095));
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 8; w++) expOut[w] = '0;
    expFrames = 0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkAllOutputs("midreset");
    adc_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    startFrame(2, 1);
    applyStimulus(2, 1, 2, 2, 0, -1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
